blram_arbiter: RTL and testbench

BLRAM_ARBITER -- requirements
Module: blram_arbiter

---
 rtl/blram_arb_pkg.sv | 10 +
 rtl/blram_arb_rr.sv | 24 ++
 rtl/blram_arbiter.sv | 127 ++++++++++++
 tb/tb_blram_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/blram_arb_pkg.sv
// Shared definitions for the two-requester block-RAM arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default RAM geometry
//   req_id_t                : 1-bit requester id (0 = r0, 1 = r1)
package blram_arb_pkg;
  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 16;
  localparam int NUM_REQ    = 2;

  typedef logic req_id_t;
endpackage

// File: rtl/blram_arb_rr.sv
// 2-way round-robin pick.
//   req  [1:0] : raw requests
//   last       : id of the most recent winner
//   mask [1:0] : eligibility mask (lock restricts it to the owner)
//   gnt  [1:0] : one-hot grant, all-zero when nobody is eligible
module blram_arb_rr
  import blram_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_id_t            last,
  input  logic [NUM_REQ-1:0] mask,
  output logic [NUM_REQ-1:0] gnt
);

  logic [NUM_REQ-1:0] elig;

  always_comb begin
    elig = req & mask;
    gnt  = elig;
    // Contest: the requester that did not win last time takes it.
    if (elig == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/blram_arbiter.sv
// Two-requester arbiter in front of a single-port, registered-output block RAM.
// One access per cycle, combinational grant, read data returned exactly one
// cycle after the grant on the owning requester's rvalid/rdata.
//   clk, rst (async, active low)
//   rN_req/we/addr/wdata    : requester N access (held until granted)
//   rN_lock                 : requester N lock (only with BLRAM_ARB_LOCK_EN)
//   rN_gnt                  : access of requester N issued this cycle
//   rN_rvalid/rdata         : read return; rdata holds while rvalid is low
//   ram_we/addr/wdata       : RAM command, zero when idle
//   ram_rdata               : RAM registered read data
// Optional feature: define BLRAM_ARB_LOCK_EN to enable requester locking.
module blram_arbiter
  import blram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
`ifdef BLRAM_ARB_LOCK_EN
  input  logic              r0_lock,
  input  logic              r1_lock,
`endif
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  logic [NUM_REQ-1:0]             req, gnt, mask;
  req_id_t                        last_q, win_id;
  logic                           win_we;
  logic                           tag_vld;
  req_id_t                        tag_id;
  logic [NUM_REQ-1:0][DATA_W-1:0] rdata_q;

  assign req    = {r1_req, r0_req};
  assign win_id = gnt[1];
  assign win_we = gnt[1] ? r1_we : r0_we;

`ifdef BLRAM_ARB_LOCK_EN
  logic    lock_act;
  req_id_t lock_own;
  logic    win_lock;

  assign win_lock = gnt[1] ? r1_lock : r0_lock;
  assign mask     = !lock_act ? 2'b11 : (lock_own ? 2'b10 : 2'b01);

  // A grant re-decides the lock from the winner's lock bit; an owner that
  // drops its request gives the lock up without an access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_act <= 1'b0;
      lock_own <= 1'b0;
    end else if (|gnt) begin
      lock_act <= win_lock;
      lock_own <= win_id;
    end else if (lock_act && !req[lock_own]) begin
      lock_act <= 1'b0;
    end
  end
`else
  assign mask = 2'b11;
`endif

  blram_arb_rr u_rr (
    .req  (req),
    .last (last_q),
    .mask (mask),
    .gnt  (gnt)
  );

  assign r0_gnt = gnt[0];
  assign r1_gnt = gnt[1];

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (gnt[0]) begin
      ram_we    = r0_we;
      ram_addr  = r0_addr;
      ram_wdata = r0_wdata;
    end else if (gnt[1]) begin
      ram_we    = r1_we;
      ram_addr  = r1_addr;
      ram_wdata = r1_wdata;
    end
  end

  // last_q resets to 1 so requester 0 wins the first contest.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q  <= 1'b1;
      tag_vld <= 1'b0;
      tag_id  <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (|gnt) last_q <= win_id;
      tag_vld <= (|gnt) && !win_we;
      tag_id  <= win_id;
      if (tag_vld) rdata_q[tag_id] <= ram_rdata;
    end
  end

  // Return data bypasses straight from the RAM in the rvalid cycle; the
  // register only holds it afterwards.
  assign r0_rvalid = tag_vld && !tag_id;
  assign r1_rvalid = tag_vld &&  tag_id;
  assign r0_rdata  = r0_rvalid ? ram_rdata : rdata_q[0];
  assign r1_rdata  = r1_rvalid ? ram_rdata : rdata_q[1];

endmodule

// File: tb/tb_blram_arbiter.sv
// Self-checking bench for blram_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// transaction-level model (grant choice, RAM command, read return).
// Define BLRAM_ARB_LOCK_EN to exercise the lock feature as well.
module tb_blram_arbiter;
  localparam int AW = 13;
  localparam int DW = 16;
`ifdef BLRAM_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
  logic          lk0 = 0, lk1 = 0;
  logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, ram_we;
  logic [DW-1:0] r0_rdata, r1_rdata, ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [AW-1:0] ram_addr;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  blram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
`ifdef BLRAM_ARB_LOCK_EN
    .r0_lock(lk0), .r1_lock(lk1),
`endif
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'((a * 37) ^ 16'h5A5A);
  endfunction

  // Registered single-port RAM; unwritten words read as init_val.
  logic [DW-1:0] mem [8192];
  bit            mem_wr [8192];
  always @(posedge clk) begin
    ram_rdata <= mem_wr[ram_addr] ? mem[ram_addr] : init_val(int'(ram_addr));
    if (ram_we) begin
      mem[ram_addr]    <= ram_wdata;
      mem_wr[ram_addr] <= 1'b1;
    end
  end

  // ---------------- reference model state ----------------
  logic [DW-1:0] ref_mem [8192];
  bit            ref_wr [8192];
  int            m_last = 1;
  bit            m_pend = 0;
  int            m_pend_id = 0;
  logic [DW-1:0] m_pend_data = '0;
  logic [DW-1:0] m_rdata [2] = '{default: '0};
  bit            m_lock = 0;
  int            m_lock_own = 0;

  // Snapshots of the DUT at the last checked cycle, for literal checks.
  logic s_gnt0, s_gnt1, s_rv0, s_rv1;
  logic [DW-1:0] s_rd1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_check();
    bit            rq [2];
    bit            wq [2];
    logic [AW-1:0] aq [2];
    logic [DW-1:0] dq [2];
    bit            lq [2];
    bit            el [2];
    int            w;
    bit            erv [2];
    logic [DW-1:0] erd [2];
    rq = '{r0_req, r1_req}; wq = '{r0_we, r1_we};
    aq = '{r0_addr, r1_addr}; dq = '{r0_wdata, r1_wdata};
    lq = '{lk0, lk1};
    s_gnt0 = r0_gnt; s_gnt1 = r1_gnt; s_rv0 = r0_rvalid; s_rv1 = r1_rvalid;
    s_rd1 = r1_rdata;
    if (!rst) begin
      chk("rst_rvalid0", r0_rvalid, 0); chk("rst_rvalid1", r1_rvalid, 0);
      chk("rst_rdata0", r0_rdata, 0);   chk("rst_rdata1", r1_rdata, 0);
      m_last = 1; m_pend = 0; m_rdata = '{default: '0}; m_lock = 0;
      return;
    end
    for (int i = 0; i < 2; i++) el[i] = rq[i] && (!m_lock || m_lock_own == i);
    if (el[0] && el[1]) w = 1 - m_last;
    else if (el[0]) w = 0;
    else if (el[1]) w = 1;
    else w = -1;
    chk("gnt0", r0_gnt, w == 0);
    chk("gnt1", r1_gnt, w == 1);
    chk("ram_we", ram_we, w >= 0 ? wq[w] : 1'b0);
    chk("ram_addr", ram_addr, w >= 0 ? aq[w] : '0);
    chk("ram_wdata", ram_wdata, w >= 0 ? dq[w] : '0);
    for (int i = 0; i < 2; i++) begin
      erv[i] = m_pend && m_pend_id == i;
      erd[i] = erv[i] ? m_pend_data : m_rdata[i];
    end
    chk("rvalid0", r0_rvalid, erv[0]); chk("rvalid1", r1_rvalid, erv[1]);
    chk("rdata0", r0_rdata, erd[0]);   chk("rdata1", r1_rdata, erd[1]);
    // advance model one cycle
    if (m_pend) m_rdata[m_pend_id] = m_pend_data;
    m_pend = 0;
    if (w >= 0) begin
      if (wq[w]) begin
        ref_mem[aq[w]] = dq[w]; ref_wr[aq[w]] = 1;
      end else begin
        m_pend = 1; m_pend_id = w;
        m_pend_data = ref_wr[aq[w]] ? ref_mem[aq[w]] : init_val(int'(aq[w]));
      end
      m_last = w;
      if (LOCK_EN) begin m_lock = lq[w]; m_lock_own = w; end
    end else if (m_lock && !rq[m_lock_own]) m_lock = 0;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int n, input bit rq, input bit we, input int a,
                       input int d, input bit lk);
    if (n == 0) begin
      r0_req = rq; r0_we = we; r0_addr = AW'(a); r0_wdata = DW'(d); lk0 = lk;
    end else begin
      r1_req = rq; r1_we = we; r1_addr = AW'(a); r1_wdata = DW'(d); lk1 = lk;
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0);
  endtask

  int n_g0, n_g1, n_acc;
  bit rv0_seen;

  initial begin
    // reset state
    idle();
    cycle(); cycle();
    rst = 1'b1;
    cycle();

    // alternating reads from both requesters, r0 first
    drive(0, 1, 0, 16'h0010, 0, 0); drive(1, 1, 0, 16'h0020, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("alt_gnt0", s_gnt0, (i % 2) == 0);
      chk("alt_gnt1", s_gnt1, (i % 2) == 1);
    end

    // write then read-after-write on the top address
    idle(); rv0_seen = 0;
    drive(0, 1, 1, 16'h1FFF, 16'hBEEF, 0);
    cycle(); rv0_seen |= s_rv0;
    idle(); drive(1, 1, 0, 16'h1FFF, 0, 0);
    cycle(); rv0_seen |= s_rv0;
    idle();
    cycle(); rv0_seen |= s_rv0;
    chk("raw_rvalid1", s_rv1, 1);
    chk("raw_rdata1", s_rd1, 16'hBEEF);
    chk("raw_no_rvalid0", rv0_seen, 0);

    // only r1 requests for 4 cycles
    n_g0 = 0; n_g1 = 0; n_acc = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 16'h0100 + i, 0, 0);
      cycle();
      n_g0 += int'(s_gnt0); n_g1 += int'(s_gnt1); n_acc += int'(s_gnt0 | s_gnt1);
    end
    chk("solo_r1_gnts", n_g1, 4);
    chk("solo_r0_gnts", n_g0, 0);
    chk("solo_accesses", n_acc, 4);

    // reset pulse right after a read grant (last winner is r1 -> r0 wins)
    drive(0, 1, 0, 16'h0030, 0, 0); drive(1, 1, 0, 16'h0040, 0, 0);
    cycle();
    idle(); #1;
    chk("pre_rst_rvalid0", r0_rvalid, 1);
    rst = 1'b0; #1;
    chk("rst_imm_rvalid0", r0_rvalid, 0);
    chk("rst_imm_rvalid1", r1_rvalid, 0);
    chk("rst_imm_rdata0", r0_rdata, 0);
    cycle();
    rst = 1'b1;
    drive(0, 1, 0, 16'h0050, 0, 0); drive(1, 1, 0, 16'h0060, 0, 0);
    cycle();
    chk("post_rst_first_gnt0", s_gnt0, 1);
    chk("post_rst_first_gnt1", s_gnt1, 0);
    idle();
    cycle();

`ifdef BLRAM_ARB_LOCK_EN
    // lock: r0 read locked, r0 write unlocked, r1 waits throughout
    rst = 1'b0; cycle(); rst = 1'b1;
    drive(0, 1, 0, 5, 0, 1); drive(1, 1, 0, 16'h0007, 0, 0);
    cycle();
    chk("lock_a_gnt0", s_gnt0, 1); chk("lock_a_gnt1", s_gnt1, 0);
    drive(0, 1, 1, 5, 16'h1234, 0);
    cycle();
    chk("lock_b_gnt0", s_gnt0, 1); chk("lock_b_gnt1", s_gnt1, 0);
    drive(0, 1, 0, 5, 0, 0);
    cycle();
    chk("lock_c_gnt1", s_gnt1, 1); chk("lock_c_gnt0", s_gnt0, 0);
    idle();
    cycle();
`endif

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      for (int n = 0; n < 2; n++) begin
        int a;
        a = ($urandom_range(0, 9) == 0) ? 16'h1FFF : int'($urandom_range(0, 7));
        drive(n, $urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, a,
              int'($urandom), LOCK_EN && ($urandom_range(0, 3) == 0));
      end
      if ($urandom_range(0, 499) == 0) begin
        idle(); rst = 1'b0; cycle(); rst = 1'b1;
      end
      cycle();
    end
    idle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
